// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-clock-domain drain engine for the asynchronous FIFO.
// It pulls words through the FIFO read port (rempty/rinc/rdata) and presents
// them as a valid/ready stream. A 3-entry skid buffer covers the FIFO's
// one-cycle registered read, so rinc never depends on m_ready.
// Optional feature: define FIFO_RD_STATS_EN to add the rd_count and
// stall_count statistics ports.
module fifo_rd_drain #(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             drain_en,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      rd_count,
    output logic [15:0]      stall_count
`endif
);

    // Skid-buffer bookkeeping.
    logic [1:0]       occ_q, occ_d;
    logic             pend_q, pend_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [DSIZE-1:0] mem_q [3];

    logic             push_s;
    logic             pop_s;
    logic             room_s;
    logic             valid_s;
    logic [DSIZE-1:0] head_data_s;

    // Pointer advance for the 3-entry ring: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] r;
        if (p == 2'd2) begin
            r = 2'd0;
        end else begin
            r = p + 2'd1;
        end
        return r;
    endfunction

    // A new read is only allowed when every in-flight word has a slot reserved.
    assign room_s  = (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);
    assign valid_s = (occ_q != 2'd0);
    assign push_s  = pend_q;
    assign pop_s   = valid_s & m_ready;

    // FIFO read request; held low while reset is asserted.
    always_comb begin
        rinc = 1'b0;
        if (rrst_n && drain_en && !rempty && room_s) begin
            rinc = 1'b1;
        end else begin
            rinc = 1'b0;
        end
    end

    // Select the word at the buffer head for the downstream port.
    always_comb begin
        head_data_s = mem_q[0];
        case (head_q)
            2'd0:    head_data_s = mem_q[0];
            2'd1:    head_data_s = mem_q[1];
            2'd2:    head_data_s = mem_q[2];
            default: head_data_s = mem_q[0];
        endcase
    end

    assign m_data  = head_data_s;
    assign m_valid = valid_s;
    assign busy    = valid_s | pend_q;

    // Next-state for occupancy, pointers and the in-flight flag.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        pend_d = rinc;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (pop_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
    end

    // Control state registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            head_q <= 2'd0;
            tail_q <= 2'd0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= pend_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Capture the word read last cycle into the buffer tail.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            mem_q[2] <= '0;
        end else if (push_s) begin
            case (tail_q)
                2'd0:    mem_q[0] <= rdata;
                2'd1:    mem_q[1] <= rdata;
                2'd2:    mem_q[2] <= rdata;
                default: mem_q[0] <= rdata;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] stall_count_q;

    // Delivered-word and backpressure-cycle counters, wrapping at 16 bits.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_count_q    <= 16'd0;
            stall_count_q <= 16'd0;
        end else begin
            if (pop_s) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (valid_s && !m_ready) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign rd_count    = rd_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a simple FIFO read-port model feeds the DUT, a
// queue-based model of the drain engine predicts every output each cycle,
// and directed scenarios pin latency, backpressure, drain_en and reset.
module tb_fifo_rd_drain;

    logic       rclk     = 1'b0;
    logic       rrst_n   = 1'b0;
    logic       rempty;
    logic [7:0] rdata    = 8'h00;
    logic       rinc;
    logic       drain_en = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready  = 1'b0;
    logic       busy;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fifo_rd_drain #(.DSIZE(8)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .drain_en (drain_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count    (rd_count),
        .stall_count (stall_count)
`endif
    );

    always #5 rclk = ~rclk;

    // FIFO read-port model: registered read, pointers shared reset.
    logic [7:0] fifo_mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign rempty = (rd_ptr == wr_ptr);

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_ptr <= 0;
            rdata  <= 8'h00;
        end else if (rinc && (rd_ptr != wr_ptr)) begin
            rdata  <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Behavioural model of the drain engine plus a log of DUT deliveries.
    logic [7:0]  mbuf [$];
    bit          mpend = 1'b0;
    logic [15:0] mrd    = 16'd0;
    logic [15:0] mstall = 16'd0;
    logic [7:0]  got_q [$];

    initial begin
        bit m_rinc;
        forever begin
            @(posedge rclk or negedge rrst_n);
            if (!rrst_n) begin
                mbuf.delete();
                mpend  = 1'b0;
                mrd    = 16'd0;
                mstall = 16'd0;
            end else begin
                m_rinc = drain_en && !rempty && ((mbuf.size() + int'(mpend)) < 3);
                if (m_valid && m_ready) got_q.push_back(m_data);
                if (mbuf.size() != 0 && !m_ready) mstall = mstall + 16'd1;
                if (mbuf.size() != 0 && m_ready) begin
                    void'(mbuf.pop_front());
                    mrd = mrd + 16'd1;
                end
                if (mpend) mbuf.push_back(rdata);
                mpend = m_rinc;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        int exp_rinc;
        forever begin
            @(negedge rclk);
            #2;
            if (!rrst_n) begin
                chk("rst_rinc", rinc, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_busy", busy, 0);
            end else begin
                exp_rinc = (drain_en && !rempty && ((mbuf.size() + int'(mpend)) < 3)) ? 1 : 0;
                chk("rinc", rinc, exp_rinc);
                chk("rinc_while_empty", int'(rinc & rempty), 0);
                chk("m_valid", m_valid, (mbuf.size() != 0) ? 1 : 0);
                if (mbuf.size() != 0) chk("m_data", m_data, mbuf[0]);
                chk("busy", busy, ((mbuf.size() != 0) || mpend) ? 1 : 0);
                chk("occ", int'(dut.occ_q), mbuf.size());
`ifdef FIFO_RD_STATS_EN
                chk("rd_count", rd_count, mrd);
                chk("stall_count", stall_count, mstall);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge rclk);
    endtask

    task automatic fifo_put(input logic [7:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk_got(input string name, input int n, input logic [7:0] base);
        chk({name, "_count"}, got_q.size(), n);
        if (got_q.size() == n) begin
            for (int i = 0; i < n; i++) chk({name, "_word"}, got_q[i], base + 8'(i));
        end
    endtask

    // Directed scenarios.
    initial begin
        int first_v;
        int pops;
        int b6;
        int b7;
        int rinc_n;
        int changes;
        int held;

        // Reset with five words queued, then full-rate drain.
        rrst_n = 1'b0; drain_en = 1'b1; m_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) fifo_put(8'(i));
        tick();
        rrst_n = 1'b1;
        got_q.delete();
        first_v = -1; pops = 0; b6 = -1; b7 = -1;
        for (int c = 0; c < 9; c++) begin
            #3;
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && m_ready && c >= 2 && c <= 6) pops++;
            if (c == 6) b6 = busy;
            if (c == 7) b7 = busy;
            tick();
        end
        chk("t1_first_valid_cycle", first_v, 2);
        chk("t1_consecutive_pops", pops, 5);
        chk("t1_busy_last_pop", b6, 1);
        chk("t1_busy_after", b7, 0);
        chk_got("t1", 5, 8'h00);

        // Backpressure with ten words queued.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fifo_put(8'h10 + 8'(i));
        rinc_n = 0; changes = 0; held = -1;
        for (int c = 0; c < 8; c++) begin
            #3;
            if (rinc) rinc_n++;
            if (m_valid) begin
                if (held < 0) held = m_data;
                else if (m_data != 8'(held)) changes++;
            end
            tick();
        end
        #3;
        chk("t2_rinc_pulses", rinc_n, 3);
        chk("t2_occ_full", int'(dut.occ_q), 3);
        chk("t2_m_data_stable", changes, 0);
        chk("t2_held_word", held, 8'h10);
        tick();
        m_ready = 1'b1;
        got_q.delete();
        repeat (20) tick();
        chk_got("t2", 10, 8'h10);

        // Alternating ready over twenty words.
        got_q.delete();
        for (int i = 0; i < 20; i++) fifo_put(8'h40 + 8'(i));
        for (int c = 0; c < 60; c++) begin
            m_ready = (c % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        chk_got("t3", 20, 8'h40);

        // drain_en dropped right after a read is issued.
        drain_en = 1'b0;
        got_q.delete();
        for (int i = 0; i < 3; i++) fifo_put(8'h60 + 8'(i));
        repeat (2) tick();
        #3;
        chk("t4_no_rinc_disabled", rinc, 0);
        tick();
        drain_en = 1'b1;
        #3;
        chk("t4_rinc_enabled", rinc, 1);
        tick();
        drain_en = 1'b0;
        rinc_n = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (rinc) rinc_n++;
            tick();
        end
        chk("t4_rinc_after_drop", rinc_n, 0);
        chk_got("t4_inflight", 1, 8'h60);
        drain_en = 1'b1;
        got_q.delete();
        repeat (10) tick();
        chk_got("t4_rest", 2, 8'h61);

        // Reset while two words are buffered and one is in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_put(8'h80 + 8'(i));
        repeat (3) tick();
        #3;
        chk("t5_occ_before", int'(dut.occ_q), 2);
        chk("t5_pend_before", int'(dut.pend_q), 1);
        chk("t5_busy_before", busy, 1);
        #1;
        rrst_n = 1'b0;
        wr_ptr = 0;
        #1;
        chk("t5_rinc_in_reset", rinc, 0);
        chk("t5_valid_in_reset", m_valid, 0);
        chk("t5_busy_in_reset", busy, 0);
        chk("t5_data_in_reset", m_data, 0);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) fifo_put(8'hA0 + 8'(i));
        m_ready = 1'b1;
        got_q.delete();
        tick();
        rrst_n = 1'b1;
        repeat (10) tick();
        chk_got("t5_after", 4, 8'hA0);

        // Seven deliveries with four stall cycles.
        rrst_n = 1'b0;
        wr_ptr = 0;
        tick();
        for (int i = 0; i < 7; i++) fifo_put(8'hC0 + 8'(i));
        m_ready = 1'b0;
        got_q.delete();
        tick();
        rrst_n = 1'b1;
        repeat (6) tick();
        m_ready = 1'b1;
        repeat (12) tick();
        #3;
        chk_got("t6", 7, 8'hC0);
        chk("t6_idle", busy, 0);
`ifdef FIFO_RD_STATS_EN
        chk("t6_rd_count", rd_count, 7);
        chk("t6_stall_count", stall_count, 4);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
